// File: rtl/cnn_pkg.sv
// cnn_pkg: types, default geometry and small helpers shared by the ReLU/max-pool stage.
//   data_t      - signed fixed-point element.
//   relu()      - clamps negative elements to zero.
//   max2()      - signed maximum of two elements.
//   cw()        - counter width for a bound n: $clog2(n), never below 1.
//   PC          - pooling windows per row (C/P) for the default geometry.
package cnn_pkg;

  localparam int M_DEF = 4;   // output feature maps per frame
  localparam int R_DEF = 4;   // input rows per map
  localparam int C_DEF = 4;   // input columns per map
  localparam int P_DEF = 2;   // pooling window edge and stride
  localparam int W_P   = 16;  // element width

  localparam int PC = C_DEF / P_DEF;

  typedef logic signed [W_P-1:0] data_t;

  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // The most negative code has its sign bit set, so it also maps to 0.
  function automatic data_t relu(input data_t x);
    return x[W_P-1] ? '0 : x;
  endfunction

  function automatic data_t max2(input data_t a, input data_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/cnn_pool_cmp.sv
// cnn_pool_cmp: combinational running-max step for one pooling window.
//   old_max  in  data_t  partial max stored for this window so far
//   new_elem in  data_t  incoming (pre-ReLU) element
//   first    in  1       element opens a new window; old_max is ignored
//   upd_max  out data_t  updated partial max (always >= 0)
module cnn_pool_cmp
  import cnn_pkg::*;
(
  input  data_t old_max,
  input  data_t new_elem,
  input  logic  first,
  output data_t upd_max
);

  data_t relu_val;

  assign relu_val = relu(new_elem);
  assign upd_max  = first ? relu_val : max2(old_max, relu_val);

endmodule

// File: rtl/cnn_relu_pool.sv
// cnn_relu_pool: streaming ReLU + non-overlapping P x P max pooling.
// Elements arrive in raster order (map, row, col); one pooled element is
// emitted per completed window over a valid/ready handshake.
//   clk_i    in   1       clock, rising edge
//   reset_i  in   1       asynchronous active-low reset
//   valid_i  in   1       input element valid
//   data_i   in   data_t  signed input element
//   ready_o  out  1       input accepted this cycle when valid_i is high
//   valid_o  out  1       pooled output valid
//   data_o   out  data_t  pooled output, always >= 0
//   last_o   out  1       final pooled element of the last map in a frame
//   ready_i  in   1       downstream accepts output
module cnn_relu_pool
  import cnn_pkg::*;
#(
  parameter int M_p = M_DEF,
  parameter int R_p = R_DEF,
  parameter int C_p = C_DEF,
  parameter int P_p = P_DEF
) (
  input  logic  clk_i,
  input  logic  reset_i,
  input  logic  valid_i,
  input  data_t data_i,
  output logic  ready_o,
  output logic  valid_o,
  output data_t data_o,
  output logic  last_o,
  input  logic  ready_i
);

  localparam int NUM_WIN = C_p / P_p;
  localparam int MW      = cw(M_p);
  localparam int RW      = cw(R_p);
  localparam int CW      = cw(C_p);
  localparam int IW      = cw(NUM_WIN);

  logic [MW-1:0] map_reg;
  logic [RW-1:0] row_reg;
  logic [CW-1:0] col_reg;

  logic  valid_reg;
  logic  last_reg;
  data_t data_reg;

  // One partial max per window column; overwritten at every window start,
  // so it needs no reset.
  data_t pmax_reg [NUM_WIN];

  logic          acc;
  logic          win_first;
  logic          win_last;
  logic          frame_end;
  logic          col_wrap;
  logic          row_wrap;
  logic          map_wrap;
  logic [IW-1:0] idx;
  data_t         upd_max;

  // Single output register without skid buffer: accept only when the
  // register is empty or being drained this cycle.
  assign ready_o = !valid_reg || ready_i;
  assign acc     = valid_i && ready_o;

  assign idx       = IW'(int'(col_reg) / P_p);
  assign win_first = (int'(row_reg) % P_p == 0) && (int'(col_reg) % P_p == 0);
  assign win_last  = (int'(row_reg) % P_p == P_p - 1) && (int'(col_reg) % P_p == P_p - 1);

  assign col_wrap  = (col_reg == CW'(C_p - 1));
  assign row_wrap  = (row_reg == RW'(R_p - 1));
  assign map_wrap  = (map_reg == MW'(M_p - 1));
  assign frame_end = map_wrap && row_wrap && col_wrap;

  // Shared by the buffer update and the output load. win_first is passed on
  // the completing element too, which matters only for the degenerate 1x1 window.
  cnn_pool_cmp u_cmp (
    .old_max  (pmax_reg[idx]),
    .new_elem (data_i),
    .first    (win_first),
    .upd_max  (upd_max)
  );

  always_ff @(posedge clk_i) begin
    if (acc && !win_last) begin
      pmax_reg[idx] <= upd_max;
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      map_reg <= '0;
      row_reg <= '0;
      col_reg <= '0;
    end else if (acc) begin
      if (col_wrap) begin
        col_reg <= '0;
        if (row_wrap) begin
          row_reg <= '0;
          // Wrap straight into the next frame without an idle cycle.
          map_reg <= map_wrap ? '0 : map_reg + MW'(1);
        end else begin
          row_reg <= row_reg + RW'(1);
        end
      end else begin
        col_reg <= col_reg + CW'(1);
      end
    end
  end

  // A window completing in the same cycle as a drain takes priority, so the
  // register reloads and valid stays high.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      valid_reg <= 1'b0;
      last_reg  <= 1'b0;
      data_reg  <= '0;
    end else if (acc && win_last) begin
      valid_reg <= 1'b1;
      last_reg  <= frame_end;
      data_reg  <= upd_max;
    end else if (valid_reg && ready_i) begin
      valid_reg <= 1'b0;
      last_reg  <= 1'b0;
    end
  end

  assign valid_o = valid_reg;
  assign last_o  = last_reg;
  assign data_o  = data_reg;

endmodule

// File: tb/tb_cnn_relu_pool.sv
// tb_cnn_relu_pool: directed bench for cnn_relu_pool at default geometry
// (4 maps of 4x4, 2x2 pooling, 16-bit data). Expected outputs are hand-computed.
module tb_cnn_relu_pool;

  logic               clk_i;
  logic               reset_i;
  logic               valid_i;
  logic signed [15:0] data_i;
  logic               ready_o;
  logic               valid_o;
  logic signed [15:0] data_o;
  logic               last_o;
  logic               ready_i;

  int cmp_cnt = 0;
  int err_cnt = 0;
  int acc_cnt = 0;
  int out_cnt = 0;
  logic [15:0] xfer_q [$];

  cnn_relu_pool dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .valid_i (valid_i),
    .data_i  (data_i),
    .ready_o (ready_o),
    .valid_o (valid_o),
    .data_o  (data_o),
    .last_o  (last_o),
    .ready_i (ready_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: apply inputs, log handshakes that happen at this edge,
  // then return 1 time unit after the rising edge.
  task automatic drive(input logic v, input logic [15:0] d, input logic r);
    valid_i = v;
    data_i  = d;
    ready_i = r;
    #1;
    if (valid_i && ready_o) acc_cnt++;
    if (valid_o && ready_i) xfer_q.push_back(data_o);
    @(posedge clk_i);
    #1;
  endtask

  // Stream one 4x4 map with ready_i=1 and check each cycle's output.
  // Windows complete at raster positions 5, 7, 13 and 15.
  task automatic stream_map(input string tag, input logic [15:0] vals [16],
                            input logic [15:0] exp [4], input logic last_map);
    int j;
    logic is_pos;
    j = 0;
    for (int k = 0; k < 16; k++) begin
      drive(1'b1, vals[k], 1'b1);
      is_pos = (k == 5) || (k == 7) || (k == 13) || (k == 15);
      check($sformatf("%s valid k=%0d", tag, k), {31'b0, valid_o}, {31'b0, is_pos});
      if (is_pos) begin
        out_cnt++;
        check($sformatf("%s data w=%0d", tag, j), {16'b0, data_o}, {16'b0, exp[j]});
        check($sformatf("%s last w=%0d", tag, j), {31'b0, last_o}, {31'b0, (last_map && j == 3)});
        j++;
      end
    end
  endtask

  initial begin
    logic [15:0] ramp [16];
    logic [15:0] neg_map [16];
    logic [15:0] mix_map [16];
    logic [15:0] down_map [16];
    logic [15:0] exp_ramp [4];
    logic [15:0] exp_zero [4];
    logic [15:0] exp_mix [4];
    logic [15:0] exp_down [4];

    for (int k = 0; k < 16; k++) begin
      ramp[k]     = 16'(k + 1);
      down_map[k] = 16'(16 - k);
      neg_map[k]  = 16'hFFFB;  // -5
    end
    neg_map[3]  = 16'h8000;
    neg_map[5]  = 16'h8000;
    neg_map[10] = 16'h8000;
    neg_map[15] = 16'h8000;
    // rows: {-3,5,-1,-2} {-7,2,-3,-4} {7,-8,32767,1} {100,3,2,3}
    mix_map  = '{16'hFFFD, 16'h0005, 16'hFFFF, 16'hFFFE,
                 16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFC,
                 16'h0007, 16'hFFF8, 16'h7FFF, 16'h0001,
                 16'h0064, 16'h0003, 16'h0002, 16'h0003};
    exp_ramp = '{16'd6, 16'd8, 16'd14, 16'd16};
    exp_zero = '{16'd0, 16'd0, 16'd0, 16'd0};
    exp_mix  = '{16'd5, 16'd0, 16'd100, 16'h7FFF};
    exp_down = '{16'd16, 16'd14, 16'd8, 16'd6};

    // Reset state
    reset_i = 1'b0;
    valid_i = 1'b0;
    data_i  = '0;
    ready_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst valid_o", {31'b0, valid_o}, 32'd0);
    check("rst data_o", {16'b0, data_o}, 32'd0);
    check("rst last_o", {31'b0, last_o}, 32'd0);
    check("rst ready_o", {31'b0, ready_o}, 32'd1);
    reset_i = 1'b1;
    drive(1'b0, 16'h0, 1'b1);

    // Full frame: four maps back-to-back, valid_i held high
    acc_cnt = 0;
    out_cnt = 0;
    stream_map("ramp m0", ramp, exp_ramp, 1'b0);
    stream_map("relu m1", neg_map, exp_zero, 1'b0);
    stream_map("mix m2", mix_map, exp_mix, 1'b0);
    stream_map("down m3", down_map, exp_down, 1'b1);
    check("frame accepted", 32'(acc_cnt), 32'd64);
    check("frame outputs", 32'(out_cnt), 32'd16);

    // Next frame restarts at map 0, so last_o stays low
    stream_map("frame2 m0", ramp, exp_ramp, 1'b0);

    // Abort a map after 7 inputs with a mid-cycle asynchronous reset
    for (int k = 0; k < 7; k++) drive(1'b1, 16'd50, 1'b1);
    check("pre-abort data_o", {16'b0, data_o}, 32'd50);
    #2 reset_i = 1'b0;
    #1;
    check("async rst valid_o", {31'b0, valid_o}, 32'd0);
    check("async rst data_o", {16'b0, data_o}, 32'd0);
    check("async rst last_o", {31'b0, last_o}, 32'd0);
    @(posedge clk_i);
    #1;
    reset_i = 1'b1;
    stream_map("post-abort", ramp, exp_ramp, 1'b0);

    // Backpressure on map 0
    reset_i = 1'b0;
    drive(1'b0, 16'h0, 1'b1);
    reset_i = 1'b1;
    drive(1'b0, 16'h0, 1'b1);
    xfer_q.delete();
    for (int k = 0; k < 6; k++) drive(1'b1, ramp[k], 1'b1);
    check("bp first valid", {31'b0, valid_o}, 32'd1);
    check("bp first data", {16'b0, data_o}, 32'd6);
    for (int s = 0; s < 5; s++) begin
      drive(1'b1, ramp[6], 1'b0);
      check($sformatf("bp hold ready_o s=%0d", s), {31'b0, ready_o}, 32'd0);
      check($sformatf("bp hold valid_o s=%0d", s), {31'b0, valid_o}, 32'd1);
      check($sformatf("bp hold data_o s=%0d", s), {16'b0, data_o}, 32'd6);
    end
    for (int k = 6; k < 16; k++) drive(1'b1, ramp[k], 1'b1);
    drive(1'b0, 16'h0, 1'b1);
    drive(1'b0, 16'h0, 1'b1);
    check("bp xfer count", 32'(xfer_q.size()), 32'd4);
    for (int j = 0; j < 4; j++) begin
      check($sformatf("bp xfer %0d", j),
            (j < xfer_q.size()) ? {16'b0, xfer_q[j]} : 32'hFFFF_FFFF,
            {16'b0, exp_ramp[j]});
    end
    check("bp idle valid_o", {31'b0, valid_o}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/cnn_relu_pool.md
Name: cnn_relu_pool

Overview:
- Streaming ReLU + max-pool stage directly downstream of the convolution engine.
- Consumes convolution output feature-map elements one per cycle in raster order: map, then row, then column.
- Applies ReLU and non-overlapping P_p x P_p max pooling.
- Emits pooled elements in raster order over a valid/ready handshake to the output writeback.

Parameters:
- M_p, 4, number of output feature maps per frame
- R_p, 4, input rows per map; must be a multiple of P_p
- C_p, 4, input columns per map; must be a multiple of P_p
- P_p, 2, pooling window edge and stride
- W_p, 16, signed fixed-point data width

Ports:
- clk_i  in  1  clock, rising edge
- reset_i  in  1  asynchronous, active-low reset
- valid_i  in  1  input element valid
- data_i  in  W_p  signed input element
- ready_o  out  1  stage can accept an input this cycle
- valid_o  out  1  pooled output valid
- data_o  out  W_p  pooled output, always >= 0
- last_o  out  1  qualifies the final pooled element of map M_p-1
- ready_i  in  1  downstream accepts output

Behaviour:
- Reset (reset_i=0, asynchronous):
  - col/row/map counters clear to 0; valid_o=0, data_o=0, last_o=0.
  - Partial-max buffer contents are don't-care; they are overwritten at each window start.
- Input acceptance: acc = valid_i && ready_o.
- ready_o = !valid_o || ready_i. This is combinational; the output stage is a single register with no skid buffer.
- ReLU: relu(x) = x[W_p-1] ? 0 : x. The most negative value maps to 0. No saturation is needed because max() never grows width.
- Partial-max buffer pmax[C_p/P_p], each W_p wide, indexed by idx = col/P_p.
- On acc at position (row, col):
  - Window first element (row%P_p==0 && col%P_p==0): pmax[idx] <= relu(data_i).
  - Window last element (row%P_p==P_p-1 && col%P_p==P_p-1):
    - data_o <= max(pmax[idx], relu(data_i)); valid_o <= 1.
    - last_o <= (map==M_p-1 && row==R_p-1 && col==C_p-1).
  - Any other element: pmax[idx] <= max(pmax[idx], relu(data_i)).
- Latency: data_o/valid_o are valid on the cycle after the window-completing input is accepted.
- Output handshake:
  - valid_o && ready_i clears valid_o and last_o, unless a new window completes in the same cycle. In that case the output register reloads and valid_o stays 1.
  - data_o and last_o are held stable while valid_o && !ready_i.
- Counters advance only on acc:
  - col wraps at C_p-1 and increments row.
  - row wraps at R_p-1 and increments map.
  - map wraps at M_p-1 to 0, so the next frame starts with no idle cycle.
- Throughput: one input per cycle when ready_i=1. Output rate is one per P_p*P_p accepted inputs.
- Backpressure: an input can never be accepted while a completed window is stuck in the output register. Data is never lost.
- Reset mid-frame: all counters return to 0 and the partial frame is discarded. The next accepted element is treated as (map 0, row 0, col 0).
- Counter widths: $clog2 of the respective bound, with a minimum of 1.

Decomposition:
- Shared package cnn_pkg:
  - data_t (logic signed [W_p-1:0]);
  - relu() and max2() functions;
  - pool geometry localparams (PC = C_p/P_p).
- One sub-module: cnn_pool_cmp.
  - Combinational: takes the old partial max, the new element and a first flag; returns the updated max.
  - Reused for both the pmax update and the output-register load.

Test Plan:
- Single map, ready_i=1, input 1..16 in raster order (R=C=4, P=2) -> data_o sequence 6, 8, 14, 16. Each appears 1 cycle after its window-completing input; last_o=0 because map 0 is not the last map.
- Map of all -5 and the value 0x8000 -> every pooled output is 0; no negative value ever appears on data_o.
- Mixed signs: window {-3, 5, -7, 2} -> 5; window {-1, -2, -3, -4} -> 0.
- Backpressure: during map 0 (input 1..16), hold ready_i=0 for 5 cycles once valid_o rises with data_o=6:
  - data_o stays 6 and ready_o stays 0;
  - after release, the remaining outputs 8, 14, 16 follow with no loss or duplication.
- Full frame: M_p=4 maps back-to-back, valid_i=1 continuously, ready_i=1:
  - 64 inputs accepted in 64 cycles, 16 outputs produced;
  - last_o high only with the 16th output;
  - the next frame's first output behaves as map 0.
- Assert reset_i=0 after 7 inputs of a map, release, then stream 1..16 -> outputs 6, 8, 14, 16, with no residue from the aborted partial map.
